pcie_tlp_bridge: RTL and testbench

// - Slave-side bridge that assembles a PCIe TLP from two sources: a 3-DW header written over APB, and payload written over AXI.
// - AXI write address and data go to a 1024-bit payload buffer; the write is acknowledged on the AXI B channel.
// - Decoded header fields, the payload buffer and the last write address are driven on flat outputs to the downstream TLP packer.

---
 rtl/pcie_tlp_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_pcie_tlp_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tlp_bridge.sv
// PCIe TLP bridge: 3-DW header over APB, single-beat AXI payload writes
// into a 1024-bit buffer, decoded fields and payload to the TLP packer.
module pcie_tlp_bridge #(
    parameter int AXI_ID_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [31:0]             paddr,
    input  logic [31:0]             pwdata,
    output logic [31:0]             prdata,
    output logic                    pready,
    output logic                    pslverr,
    input  logic [AXI_ID_WIDTH-1:0] awid,
    input  logic [31:0]             awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [AXI_ID_WIDTH-1:0] wid,
    input  logic [127:0]            wdata,
    input  logic [15:0]             wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [AXI_ID_WIDTH-1:0] bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [2:0]              header_fmt_o,
    output logic [4:0]              header_type_o,
    output logic [2:0]              header_tc_o,
    output logic [8:0]              header_length_o,
    output logic [15:0]             header_requestID_o,
    output logic [15:0]             header_completID_o,
    output logic [1023:0]           data_out,
    output logic [31:0]             addr_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_W  = 2'd1;
    localparam logic [1:0] WAIT_AW = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [31:0] dw0_q, dw1_q, dw2_q;
    logic [31:0] dw0_d, dw1_d, dw2_d;
    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [AXI_ID_WIDTH-1:0] bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        bvalid_q, bvalid_d;
    logic [127:0] wdata_q, wdata_d;
    logic [15:0] wstrb_q, wstrb_d;
    logic [1023:0] data_q, data_d;

    logic        apb_access;
    logic        apb_bad;
    logic        apb_wr;
    logic        aw_hs;
    logic        w_hs;
    logic        commit;
    logic [31:0] addr_eff;
    logic [127:0] wdata_eff;
    logic [15:0] wstrb_eff;
    logic [2:0]  slot_eff;

    // Burst controls and W ID are ignored: every transfer is one beat.
    logic unused_ok;
    assign unused_ok = ^{awlen, awsize, awburst, wlast, wid,
                         paddr[31:4], paddr[1:0]};

    // ---------------- APB header registers ----------------
    assign apb_access = psel & penable;
    assign apb_bad    = (paddr[3:2] == 2'd3);
    assign apb_wr     = apb_access & pwrite & ~apb_bad;
    assign pready     = 1'b1;
    assign pslverr    = apb_access & apb_bad;

    always_comb begin
        prdata = 32'h0;
        case (paddr[3:2])
            2'd0:    prdata = dw0_q;
            2'd1:    prdata = dw1_q;
            2'd2:    prdata = dw2_q;
            default: prdata = 32'h0;
        endcase
    end

    always_comb begin
        dw0_d = dw0_q;
        dw1_d = dw1_q;
        dw2_d = dw2_q;
        if (apb_wr) begin
            case (paddr[3:2])
                2'd0:    dw0_d = pwdata;
                2'd1:    dw1_d = pwdata;
                2'd2:    dw2_d = pwdata;
                default: ;
            endcase
        end
    end

    assign header_fmt_o       = dw0_q[31:29];
    assign header_type_o      = dw0_q[28:24];
    assign header_tc_o        = dw0_q[22:20];
    assign header_length_o    = dw0_q[8:0];
    assign header_requestID_o = dw1_q[31:16];
    assign header_completID_o = dw2_q[31:16];

    // ---------------- AXI write FSM ----------------
    assign awready = (state_q == IDLE) | (state_q == WAIT_AW);
    assign wready  = (state_q == IDLE) | (state_q == WAIT_W);
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_hs && w_hs)  state_d = RESP;
                else if (aw_hs)     state_d = WAIT_W;
                else if (w_hs)      state_d = WAIT_AW;
            end
            WAIT_W:  if (w_hs)   state_d = RESP;
            WAIT_AW: if (aw_hs)  state_d = RESP;
            RESP:    if (bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign commit = (state_q != RESP) && (state_d == RESP);

    // The completing handshake's values are used directly this cycle.
    assign addr_eff  = aw_hs ? awaddr : addr_q;
    assign wdata_eff = w_hs ? wdata : wdata_q;
    assign wstrb_eff = w_hs ? wstrb : wstrb_q;
    assign slot_eff  = addr_eff[6:4];

    always_comb begin
        addr_d  = addr_q;
        bid_d   = bid_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        bresp_d = bresp_q;
        if (aw_hs) begin
            addr_d = awaddr;
            bid_d  = awid;
        end
        if (w_hs) begin
            wdata_d = wdata;
            wstrb_d = wstrb;
        end
        if (commit) begin
            bresp_d = 2'b00;
        end
    end

    always_comb begin
        bvalid_d = bvalid_q;
        if (commit) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_comb begin
        data_d = data_q;
        if (commit) begin
            for (int b = 0; b < 16; b++) begin
                if (wstrb_eff[b]) begin
                    data_d[128*int'(slot_eff) + 8*b +: 8] =
                        wdata_eff[8*b +: 8];
                end
            end
        end
    end

    assign bid      = bid_q;
    assign bresp    = bresp_q;
    assign bvalid   = bvalid_q;
    assign data_out = data_q;
    assign addr_out = addr_q;

    // rst_n is active-high in this codebase despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dw0_q    <= 32'h0;
            dw1_q    <= 32'h0;
            dw2_q    <= 32'h0;
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            bid_q    <= '0;
            bresp_q  <= 2'b00;
            bvalid_q <= 1'b0;
            wdata_q  <= 128'h0;
            wstrb_q  <= 16'h0;
            data_q   <= '0;
        end else begin
            dw0_q    <= dw0_d;
            dw1_q    <= dw1_d;
            dw2_q    <= dw2_d;
            state_q  <= state_d;
            addr_q   <= addr_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            bvalid_q <= bvalid_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_pcie_tlp_bridge.sv
// Directed bench for pcie_tlp_bridge: header decode, AXI payload
// writes, ordering/backpressure, strobes, APB error and async reset.
module tb_pcie_tlp_bridge;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          psel, penable, pwrite;
    logic [31:0]   paddr, pwdata, prdata;
    logic          pready, pslverr;
    logic [3:0]    awid, wid, bid;
    logic [31:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [127:0]  wdata;
    logic [15:0]   wstrb;
    logic          wlast, wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [2:0]    fmt, tc;
    logic [4:0]    typ;
    logic [8:0]    len;
    logic [15:0]   reqid, cplid;
    logic [1023:0] data_out;
    logic [31:0]   addr_out;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] PAT = {4{32'h01234567}};
    localparam logic [127:0] PB  = 128'hA5A5_5A5A_1122_3344_5566_7788_99AA_BBCC;

    pcie_tlp_bridge #(.AXI_ID_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .header_fmt_o(fmt), .header_type_o(typ), .header_tc_o(tc),
        .header_length_o(len), .header_requestID_o(reqid),
        .header_completID_o(cplid),
        .data_out(data_out), .addr_out(addr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1023:0] obs,
                       input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        #1;
        chk("pslverr_ok", {1023'b0, pslverr}, 1024'd0);
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        awid = 0; wid = 0; awaddr = 0; awlen = 0; awsize = 3'd4;
        awburst = 2'b01; awvalid = 0; wdata = 0; wstrb = 0;
        wlast = 1; wvalid = 0; bready = 0;

        // T1 reset
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("rst_bvalid", {1023'b0, bvalid}, 1024'd0);
        chk("rst_awready", {1023'b0, awready}, 1024'd1);
        chk("rst_wready", {1023'b0, wready}, 1024'd1);
        chk("rst_pready", {1023'b0, pready}, 1024'd1);
        chk("rst_bid", {1020'b0, bid}, 1024'd0);
        chk("rst_bresp", {1022'b0, bresp}, 1024'd0);
        chk("rst_data", data_out, 1024'd0);
        chk("rst_addr", {992'b0, addr_out}, 1024'd0);
        chk("rst_hdr", {968'b0, fmt, typ, tc, len, reqid, cplid},
            1024'd0);

        // T2 header writes
        apb_write(32'h0, 32'h01234567);
        apb_write(32'h4, 32'h01234567);
        apb_write(32'h8, 32'h01234567);
        chk("fmt", {1021'b0, fmt}, 1024'd0);
        chk("type", {1019'b0, typ}, 1024'h01);
        chk("tc", {1021'b0, tc}, 1024'h2);
        chk("length", {1015'b0, len}, 1024'h167);
        chk("reqid", {1008'b0, reqid}, 1024'h0123);
        chk("cplid", {1008'b0, cplid}, 1024'h0123);
        paddr = 32'h4;
        #1;
        chk("prdata_dw1", {992'b0, prdata}, 1024'h01234567);

        // T3 AW+W same cycle
        awid = 4'd0; awaddr = 32'h0; wdata = PAT; wstrb = 16'hFFFF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("t3_bvalid", {1023'b0, bvalid}, 1024'd1);
        chk("t3_bid", {1020'b0, bid}, 1024'd0);
        chk("t3_bresp", {1022'b0, bresp}, 1024'd0);
        chk("t3_slot0", {896'b0, data_out[127:0]}, {896'b0, PAT});
        chk("t3_addr", {992'b0, addr_out}, 1024'd0);
        chk("t3_awready", {1023'b0, awready}, 1024'd0);
        bready = 1;
        tick();
        bready = 0;
        chk("t3_bvalid_off", {1023'b0, bvalid}, 1024'd0);
        chk("t3_idle_rdy", {1022'b0, awready, wready}, 1024'd3);

        // T4 second write to slot 2
        awid = 4'd5; awaddr = 32'd32; wdata = PAT; wstrb = 16'hFFFF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("t4_bid", {1020'b0, bid}, 1024'd5);
        chk("t4_slot2", {896'b0, data_out[383:256]}, {896'b0, PAT});
        chk("t4_slot0", {896'b0, data_out[127:0]}, {896'b0, PAT});
        chk("t4_slot1", {896'b0, data_out[255:128]}, 1024'd0);
        chk("t4_addr", {992'b0, addr_out}, 1024'd32);
        bready = 1;
        tick();
        bready = 0;

        // T5 W two cycles before AW, bready held low
        wdata = PB; wstrb = 16'hFFFF; wvalid = 1;
        tick();
        wvalid = 0;
        chk("t5_waitaw_rdy", {1022'b0, awready, wready}, 1024'd2);
        chk("t5_nobvalid", {1023'b0, bvalid}, 1024'd0);
        tick();
        awid = 4'd9; awaddr = 32'h10; awvalid = 1;
        tick();
        awaddr = 32'h70; awid = 4'd3; wdata = 128'hFFFF; wvalid = 1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_bvalid", {1023'b0, bvalid}, 1024'd1);
            chk("t5_hold_bid", {1020'b0, bid}, 1024'd9);
            chk("t5_hold_bresp", {1022'b0, bresp}, 1024'd0);
            chk("t5_blocked", {1022'b0, awready, wready}, 1024'd0);
            tick();
        end
        chk("t5_slot1", {896'b0, data_out[255:128]}, {896'b0, PB});
        chk("t5_addr", {992'b0, addr_out}, 1024'h10);
        awvalid = 0; wvalid = 0; bready = 1;
        tick();
        bready = 0;
        chk("t5_single_pulse", {1023'b0, bvalid}, 1024'd0);
        chk("t5_slot7", {896'b0, data_out[1023:896]}, 1024'd0);
        chk("t5_addr_kept", {992'b0, addr_out}, 1024'h10);

        // T6 partial strobes into slot 1
        awid = 4'd1; awaddr = 32'h10; wdata = 128'h0000_0000_DEAD_BEEF;
        wdata[127:32] = 96'hCAFE_CAFE_CAFE_CAFE_CAFE_CAFE;
        wstrb = 16'h000F; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; bready = 1;
        tick();
        bready = 0;
        chk("t6_low32", {992'b0, data_out[159:128]}, 1024'hDEADBEEF);
        chk("t6_rest", {928'b0, data_out[255:160]},
            {928'b0, PB[127:32]});
        chk("t6_slot2", {896'b0, data_out[383:256]}, {896'b0, PAT});

        // T6 APB error at 0xC
        psel = 1; penable = 0; pwrite = 1;
        paddr = 32'hC; pwdata = 32'hFFFF_FFFF;
        tick();
        penable = 1;
        #1;
        chk("t6_pslverr", {1023'b0, pslverr}, 1024'd1);
        chk("t6_prdata_c", {992'b0, prdata}, 1024'd0);
        tick();
        psel = 0; penable = 0; pwrite = 0;
        chk("t6_hdr_kept", {968'b0, fmt, typ, tc, len, reqid, cplid},
            {968'b0, 3'd0, 5'h01, 3'h2, 9'h167, 16'h0123, 16'h0123});
        paddr = 32'h8;
        #1;
        chk("t6_dw2", {992'b0, prdata}, 1024'h01234567);

        // Async reset mid-transaction
        awid = 4'd7; awaddr = 32'h20; wdata = PAT; wstrb = 16'hFFFF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("ar_bvalid_pre", {1023'b0, bvalid}, 1024'd1);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ar_bvalid", {1023'b0, bvalid}, 1024'd0);
        chk("ar_data", data_out, 1024'd0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("ar_idle_rdy", {1022'b0, awready, wready}, 1024'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
